data_ram_be: RTL

DATA_RAM_BE -- requirements
Module: data_ram_be

---
 rtl/data_ram_be.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/data_ram_be.sv
// Byte-enabled single-port data RAM with a power-up zeroing sweep and a
// fixed-latency, in-order response pipeline (1 or 2 cycles).
module data_ram_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              vld_p1_q, vld_p1_d;
  logic              err_p1_q, err_p1_d;
  logic [DATA_W-1:0] rdata_p1_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              mem_en;
  logic [NB-1:0]     mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  assign ready    = (state_q == RUN);
  assign in_range = ({1'b0, addr} < DEPTH_C);

  always_comb begin
    accept    = req && (state_q == RUN);
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == LAST_IDX) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end

    vld_p1_d  = accept;
    err_p1_d  = accept && !in_range;

    // The sweep owns the single RAM port while in CLEAR; out-of-range
    // requests never touch the array.
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_idx   = addr[IDX_W-1:0];
    mem_wdata = wdata;
    if (state_q == CLEAR) begin
      mem_en    = 1'b1;
      mem_we    = '1;
      mem_idx   = cnt_q;
      mem_wdata = '0;
    end else if (accept && in_range) begin
      mem_en    = 1'b1;
      mem_we    = we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      vld_p1_q <= 1'b0;
      err_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_p1_q <= vld_p1_d;
      err_p1_q <= err_p1_d;
    end
  end

  // Stage p1: byte-write RAM with write-first registered read
  always_ff @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_we[i]) begin
          mem[mem_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
          rdata_p1_q[i*8 +: 8]   <= mem_wdata[i*8 +: 8];
        end else begin
          rdata_p1_q[i*8 +: 8]   <= mem[mem_idx][i*8 +: 8];
        end
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              vld_p2_q, vld_p2_d;
      logic              err_p2_q, err_p2_d;
      logic [DATA_W-1:0] rdata_p2_q, rdata_p2_d;

      always_comb begin
        vld_p2_d   = vld_p1_q;
        err_p2_d   = err_p1_q;
        rdata_p2_d = rdata_p1_q;
      end

      // Stage p2: extra output register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p2_q <= 1'b0;
          err_p2_q <= 1'b0;
        end else begin
          vld_p2_q <= vld_p2_d;
          err_p2_q <= err_p2_d;
        end
      end

      always_ff @(posedge clk) begin
        rdata_p2_q <= rdata_p2_d;
      end

      assign rvalid = vld_p2_q;
      assign err    = vld_p2_q && err_p2_q;
      assign rdata  = (vld_p2_q && !err_p2_q) ? rdata_p2_q : '0;
    end else begin : g_lat1
      assign rvalid = vld_p1_q;
      assign err    = vld_p1_q && err_p1_q;
      assign rdata  = (vld_p1_q && !err_p1_q) ? rdata_p1_q : '0;
    end
  endgenerate

endmodule
